// File: rtl/arith_pkg.sv
// Shared definitions for the sequential multiply/divide arithmetic units.
// Both units use the same state encoding so one controller can sequence either.
package arith_pkg;

    localparam int DEF_W  = 32;
    localparam int DEF_CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } arith_state_t;

    // Results are 64 bits wide; callers cast them down to their operand width W.
    function automatic logic [63:0] most_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] all_ones(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/booths_signed_div32_if.sv
// Start/Ready/Done handshake and operand/result bus for the signed divider.
// The controller drives the master modport and the divider implements the slave modport.
interface booths_signed_div32_if
    import arith_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
);

    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Start;
    logic [W-1:0]  Quotient;
    logic [W-1:0]  Remainder;
    logic          Ready;
    logic          Done;
    logic          DivByZero;
    logic          Overflow;
    logic [CW-1:0] CountReg;

    modport master (
        output A, B, Start,
        input  Quotient, Remainder, Ready, Done, DivByZero, Overflow, CountReg
    );

    modport slave (
        input  A, B, Start,
        output Quotient, Remainder, Ready, Done, DivByZero, Overflow, CountReg
    );

endinterface

// File: rtl/div_restore_step.sv
// One radix-2 restoring-division iteration on magnitudes (combinational).
// The dividend is shifted out of the top of q while quotient bits enter at the bottom.
module div_restore_step
    import arith_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   p,
    input  logic [W-1:0] q,
    input  logic [W-1:0] b_mag,
    output logic [W:0]   p_next,
    output logic [W-1:0] q_next
);

    logic [W+1:0] p_sh;
    logic [W+1:0] trial;
    logic         fits;

    // Two extra bits give room for the shifted value and a clean borrow/sign bit.
    always_comb begin
        p_sh  = {p, q[W-1]};
        trial = p_sh - {2'b00, b_mag};
        fits  = ~trial[W+1];
        if (fits) begin
            p_next = trial[W:0];
        end else begin
            p_next = p_sh[W:0];
        end
        q_next = {q[W-2:0], fits};
    end

endmodule

// File: rtl/booths_signed_div32.sv
// Sequential signed divider: W restoring iterations on the operand magnitudes plus one sign-fix cycle.
// The quotient truncates toward zero, and the remainder takes the sign of the dividend.
module booths_signed_div32
    import arith_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booths_signed_div32_if.slave bus
);

    localparam logic [W-1:0] MOST_NEG = W'(most_neg(W));
    localparam logic [W-1:0] ALL_ONES = W'(all_ones(W));

    arith_state_t  state;
    arith_state_t  next_state;

    logic [W:0]    p_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  b_mag;
    logic          sign_a;
    logic          q_neg;
    logic          dbz_sel;
    logic          ovf_sel;
    logic [CW-1:0] count_r;

    logic [W-1:0]  quotient_r;
    logic [W-1:0]  remainder_r;
    logic          done_r;
    logic          dbz_r;
    logic          ovf_r;

    logic [W-1:0]  a_mag_in;
    logic [W-1:0]  b_mag_in;
    logic          b_zero;
    logic [W:0]    p_step;
    logic [W-1:0]  q_step;

    assign a_mag_in = bus.A[W-1] ? (~bus.A + 1'b1) : bus.A;
    assign b_mag_in = bus.B[W-1] ? (~bus.B + 1'b1) : bus.B;
    assign b_zero   = (bus.B == '0);

    div_restore_step #(.W(W)) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .b_mag  (b_mag),
        .p_next (p_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    next_state = b_zero ? FIX : ITER;
                end
            end
            ITER: begin
                if (count_r == CW'(1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg       <= '0;
            q_reg       <= '0;
            b_mag       <= '0;
            sign_a      <= 1'b0;
            q_neg       <= 1'b0;
            dbz_sel     <= 1'b0;
            ovf_sel     <= 1'b0;
            count_r     <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        // q_reg starts out holding |A|. Each step shifts one dividend bit out of the top and one quotient bit into the bottom.
                        q_reg   <= a_mag_in;
                        b_mag   <= b_mag_in;
                        sign_a  <= bus.A[W-1];
                        q_neg   <= bus.A[W-1] ^ bus.B[W-1];
                        dbz_sel <= b_zero;
                        ovf_sel <= (bus.A == MOST_NEG) && (bus.B == ALL_ONES);
                        if (b_zero) begin
                            // The sign fix on |A| rebuilds A itself as the remainder.
                            p_reg   <= {1'b0, a_mag_in};
                            count_r <= '0;
                        end else begin
                            p_reg   <= '0;
                            count_r <= CW'(W);
                        end
                    end
                end
                ITER: begin
                    p_reg   <= p_step;
                    q_reg   <= q_step;
                    count_r <= count_r - CW'(1);
                end
                FIX: begin
                    if (dbz_sel) begin
                        quotient_r <= ALL_ONES;
                    end else begin
                        quotient_r <= q_neg ? (~q_reg + 1'b1) : q_reg;
                    end
                    remainder_r <= sign_a ? (~p_reg[W-1:0] + 1'b1) : p_reg[W-1:0];
                    dbz_r       <= dbz_sel;
                    ovf_r       <= ovf_sel;
                    done_r      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Quotient  = quotient_r;
    assign bus.Remainder = remainder_r;
    assign bus.Ready     = (state == IDLE);
    assign bus.Done      = done_r;
    assign bus.DivByZero = dbz_r;
    assign bus.Overflow  = ovf_r;
    assign bus.CountReg  = count_r;

endmodule

// File: tb/tb_booths_signed_div32.sv
// Directed-vector bench for booths_signed_div32, covering the sign matrix, divide-by-zero,
// overflow, an ignored mid-op Start, a back-to-back Start and reset in mid-operation.
module tb_booths_signed_div32;
    import arith_pkg::*;

    localparam int W  = 32;
    localparam int CW = 6;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    booths_signed_div32_if #(.W(W), .CW(CW)) bus ();

    booths_signed_div32 #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.Done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        start_op(v.a, v.b);
        check({tag, "_ready_drop"}, 64'(bus.Ready), 64'(0));
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_quotient"}, 64'(bus.Quotient), 64'(v.q));
        check({tag, "_remainder"}, 64'(bus.Remainder), 64'(v.r));
        check({tag, "_divbyzero"}, 64'(bus.DivByZero), 64'(v.dbz));
        check({tag, "_overflow"}, 64'(bus.Overflow), 64'(v.ovf));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.Done), 64'(0));
        check({tag, "_q_hold"}, 64'(bus.Quotient), 64'(v.q));
    endtask

    vec_t vecs[13];
    vec_t post_rst;

    initial begin
        int lat;
        int n;
        int done_seen;

        vecs[0]  = '{32'hFFFF_FF87, 32'hFFFF_FFF5, 32'h0000_000B, 32'h0000_0000, 1'b0, 1'b0, 33};
        vecs[1]  = '{32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0, 33};
        vecs[2]  = '{32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[4]  = '{32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b0, 33};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0, 1};
        vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 33};
        vecs[7]  = '{32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1};
        vecs[8]  = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 33};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 33};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 33};
        vecs[11] = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 33};
        vecs[12] = '{32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 1'b0, 1'b0, 33};
        post_rst = '{32'h0000_03E8, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 32'h0000_0000, 1'b0, 1'b0, 33};

        bus.A     = '0;
        bus.B     = '0;
        bus.Start = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_quotient", 64'(bus.Quotient), 64'(0));
        check("rst_remainder", 64'(bus.Remainder), 64'(0));
        check("rst_done", 64'(bus.Done), 64'(0));
        check("rst_divbyzero", 64'(bus.DivByZero), 64'(0));
        check("rst_overflow", 64'(bus.Overflow), 64'(0));
        check("rst_countreg", 64'(bus.CountReg), 64'(0));
        check("rst_ready", 64'(bus.Ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // 100/7 with a second Start (9/3) presented at cycle 5; that Start must be ignored.
        start_op(32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.A     = 32'd9;
        bus.B     = 32'd3;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        check("busy_ready", 64'(bus.Ready), 64'(0));
        check("busy_countreg", 64'(bus.CountReg), 64'(27));
        wait_done(lat);
        check("busy_latency", 64'(lat + 5), 64'(33));
        check("busy_quotient", 64'(bus.Quotient), 64'(14));
        check("busy_remainder", 64'(bus.Remainder), 64'(2));
        check("done_cycle_ready", 64'(bus.Ready), 64'(1));

        // Back-to-back: a new Start is presented in the same cycle Done is high.
        start_op(32'd9, 32'd3);
        check("b2b_done_drop", 64'(bus.Done), 64'(0));
        check("b2b_countreg", 64'(bus.CountReg), 64'(32));
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'(33));
        check("b2b_quotient", 64'(bus.Quotient), 64'(3));
        check("b2b_remainder", 64'(bus.Remainder), 64'(0));

        // Reset mid-operation when CountReg reaches 20.
        start_op(32'd50, 32'd7);
        n = 0;
        while (bus.CountReg !== CW'(20) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst_countreg_seen", 64'(bus.CountReg), 64'(20));
        rst_n = 1'b0;
        #1;
        check("midrst_quotient", 64'(bus.Quotient), 64'(0));
        check("midrst_remainder", 64'(bus.Remainder), 64'(0));
        check("midrst_countreg", 64'(bus.CountReg), 64'(0));
        check("midrst_ready", 64'(bus.Ready), 64'(1));
        check("midrst_done", 64'(bus.Done), 64'(0));
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.Done === 1'b1) done_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.Done === 1'b1) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'(0));
        check("midrst_idle_ready", 64'(bus.Ready), 64'(1));

        run_vec(post_rst, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
